// File: rtl/lstm_q6_11_pkg.sv
// lstm_q6_11_pkg: Q6.11 constants, PLAN sigmoid breakpoints and the width reduction helper.
// Reduction saturates when LSTM_CELL_SAT_EN is defined, otherwise wraps.
package lstm_q6_11_pkg;
    localparam int WIDTH = 18;
    localparam int FRAC  = 11;
    localparam int ACC   = 2 * WIDTH + 1;
    localparam logic [WIDTH-1:0] ONE     = 18'd2048;
    localparam logic [WIDTH:0]   BP_MID  = 19'd2048;
    localparam logic [WIDTH:0]   BP_HI   = 19'd4864;
    localparam logic [WIDTH:0]   BP_SAT  = 19'd10240;
    localparam logic [WIDTH-1:0] OFF_LO  = 18'd1024;
    localparam logic [WIDTH-1:0] OFF_MID = 18'd1280;
    localparam logic [WIDTH-1:0] OFF_HI  = 18'd1728;
    localparam logic signed [WIDTH-1:0] W_MAX = 18'sh1FFFF;
    localparam logic signed [WIDTH-1:0] W_MIN = 18'sh20000;
    localparam logic signed [ACC-1:0]   A_MAX = 37'sh0_0001_FFFF;
    localparam logic signed [ACC-1:0]   A_MIN = -37'sh0_0002_0000;

    function automatic logic signed [WIDTH-1:0] reduce(input logic signed [ACC-1:0] v);
`ifdef LSTM_CELL_SAT_EN
        return (v > A_MAX) ? W_MAX : (v < A_MIN) ? W_MIN : v[WIDTH-1:0];
`else
        return v[WIDTH-1:0];
`endif
    endfunction
endpackage

// File: rtl/lstm_act_pwl.sv
// lstm_act_pwl: PLAN piecewise-linear sigmoid; tanh_i=1 yields tanh(p) = 2*sig(2p) - 1.
module lstm_act_pwl
    import lstm_q6_11_pkg::*;
(
    input  logic signed [WIDTH-1:0] p_i,
    input  logic                    tanh_i,
    output logic signed [WIDTH-1:0] y_o
);
    logic signed [WIDTH:0] v;
    logic [WIDTH:0]        a;
    logic [WIDTH-1:0]      m, s;

    // 2p is formed one bit wider so the doubling can never overflow
    assign v = tanh_i ? {p_i, 1'b0} : {p_i[WIDTH-1], p_i};
    assign a = v[WIDTH] ? ((v == {1'b1, {WIDTH{1'b0}}}) ? {1'b0, {WIDTH{1'b1}}} : -v) : v;
    assign m = (a >= BP_SAT) ? ONE :
               (a >= BP_HI)  ? WIDTH'(a >> 5) + OFF_HI :
               (a >= BP_MID) ? WIDTH'(a >> 3) + OFF_MID :
                               WIDTH'(a >> 2) + OFF_LO;
    assign s = v[WIDTH] ? ONE - m : m;
    assign y_o = tanh_i ? (s << 1) - ONE : s;
endmodule

// File: rtl/lstm_cell_q6_11.sv
// lstm_cell_q6_11: single-step LSTM cell, Q6.11, combinational datapath into c_t/h_t registers.
// Define LSTM_CELL_SAT_EN for saturating reductions; default build wraps.
module lstm_cell_q6_11
    import lstm_q6_11_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [WIDTH-1:0] x_t,
    input  logic signed [WIDTH-1:0] c_prev,
    input  logic signed [WIDTH-1:0] h_prev,
    input  logic signed [WIDTH-1:0] W_fx,
    input  logic signed [WIDTH-1:0] W_fh,
    input  logic signed [WIDTH-1:0] b_f,
    input  logic signed [WIDTH-1:0] W_ix,
    input  logic signed [WIDTH-1:0] W_ih,
    input  logic signed [WIDTH-1:0] b_i,
    input  logic signed [WIDTH-1:0] W_gx,
    input  logic signed [WIDTH-1:0] W_gh,
    input  logic signed [WIDTH-1:0] b_g,
    input  logic signed [WIDTH-1:0] W_ox,
    input  logic signed [WIDTH-1:0] W_oh,
    input  logic signed [WIDTH-1:0] b_o,
    output logic signed [WIDTH-1:0] c_t,
    output logic signed [WIDTH-1:0] h_t
);
    logic signed [WIDTH-1:0] pf, pi, pg, po, f, i, g, o, tc;
    logic signed [WIDTH-1:0] c_d, h_d, c_q, h_q;

    function automatic logic signed [WIDTH-1:0] preact(
        input logic signed [WIDTH-1:0] wx, wh, b);
        logic signed [ACC-1:0] sum;
        sum = ACC'(wx * x_t) + ACC'(wh * h_prev);
        return reduce((sum >>> FRAC) + ACC'(b));
    endfunction

    assign pf = preact(W_fx, W_fh, b_f);
    assign pi = preact(W_ix, W_ih, b_i);
    assign pg = preact(W_gx, W_gh, b_g);
    assign po = preact(W_ox, W_oh, b_o);

    lstm_act_pwl u_f (.p_i(pf),  .tanh_i(1'b0), .y_o(f));
    lstm_act_pwl u_i (.p_i(pi),  .tanh_i(1'b0), .y_o(i));
    lstm_act_pwl u_g (.p_i(pg),  .tanh_i(1'b1), .y_o(g));
    lstm_act_pwl u_o (.p_i(po),  .tanh_i(1'b0), .y_o(o));
    lstm_act_pwl u_c (.p_i(c_d), .tanh_i(1'b1), .y_o(tc));

    assign c_d = reduce((ACC'(f * c_prev) >>> FRAC) + (ACC'(i * g) >>> FRAC));
    assign h_d = reduce(ACC'(o * tc) >>> FRAC);

    always_ff @(posedge clk) begin
        if (rst) begin
            c_q <= '0;
            h_q <= '0;
        end else begin
            c_q <= c_d;
            h_q <= h_d;
        end
    end

    assign c_t = c_q;
    assign h_t = h_q;
endmodule

// File: tb/tb_lstm_cell_q6_11.sv
// tb_lstm_cell_q6_11: directed checks plus a randomized recurrent sweep against an integer reference model.
module tb_lstm_cell_q6_11;
    logic clk = 1'b0;
    logic rst;
    logic signed [17:0] x_t, c_prev, h_prev, c_t, h_t;
    logic signed [17:0] W_fx, W_fh, b_f, W_ix, W_ih, b_i, W_gx, W_gh, b_g, W_ox, W_oh, b_o;
    int w [12];
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign W_fx = 18'(w[0]);
    assign W_fh = 18'(w[1]);
    assign b_f  = 18'(w[2]);
    assign W_ix = 18'(w[3]);
    assign W_ih = 18'(w[4]);
    assign b_i  = 18'(w[5]);
    assign W_gx = 18'(w[6]);
    assign W_gh = 18'(w[7]);
    assign b_g  = 18'(w[8]);
    assign W_ox = 18'(w[9]);
    assign W_oh = 18'(w[10]);
    assign b_o  = 18'(w[11]);

    lstm_cell_q6_11 dut (
        .clk(clk), .rst(rst), .x_t(x_t), .c_prev(c_prev), .h_prev(h_prev),
        .W_fx(W_fx), .W_fh(W_fh), .b_f(b_f), .W_ix(W_ix), .W_ih(W_ih), .b_i(b_i),
        .W_gx(W_gx), .W_gh(W_gh), .b_g(b_g), .W_ox(W_ox), .W_oh(W_oh), .b_o(b_o),
        .c_t(c_t), .h_t(h_t)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int red(longint v);
`ifdef LSTM_CELL_SAT_EN
        return v > 131071 ? 131071 : v < -131072 ? -131072 : int'(v);
`else
        longint m = v & 64'h3FFFF;
        return int'(m >= 131072 ? m - 262144 : m);
`endif
    endfunction

    function automatic int sig(longint p);
        longint a = p < 0 ? -p : p;
        longint y;
        y = a >= 10240 ? 2048 : a >= 4864 ? a / 32 + 1728 : a >= 2048 ? a / 8 + 1280 : a / 4 + 1024;
        return int'(p < 0 ? 2048 - y : y);
    endfunction

    function automatic int th(longint v);
        return 2 * sig(2 * v) - 2048;
    endfunction

    function automatic int gate(int k, int x, int h);
        return red(((longint'(w[3*k]) * x + longint'(w[3*k+1]) * h) >>> 11) + w[3*k+2]);
    endfunction

    task automatic model(input int x, cp, hp, output int c, h);
        int f, i, g, o;
        f = sig(gate(0, x, hp));
        i = sig(gate(1, x, hp));
        g = th(gate(2, x, hp));
        o = sig(gate(3, x, hp));
        c = red(((longint'(f) * cp) >>> 11) + ((longint'(i) * g) >>> 11));
        h = red((longint'(o) * th(c)) >>> 11);
    endtask

    task automatic step(input string tag, input int x, cp, hp, input bit r, output int ec, eh);
        rst = r;
        x_t = 18'(x);
        c_prev = 18'(cp);
        h_prev = 18'(hp);
        if (r) begin
            ec = 0;
            eh = 0;
        end else model(x, cp, hp, ec, eh);
        @(posedge clk);
        #1;
        chk({tag, ".c"}, int'(c_t), ec);
        chk({tag, ".h"}, int'(h_t), eh);
    endtask

    function automatic int rnd(int lim);
        return int'($urandom_range(0, 2 * lim)) - lim;
    endfunction

    initial begin
        int ec, eh, mc, mh, n;
        foreach (w[k]) w[k] = rnd(4096);
        step("rst0", rnd(131071), rnd(131071), rnd(131071), 1'b1, ec, eh);
        step("rst1", rnd(131071), rnd(131071), rnd(131071), 1'b1, ec, eh);
        step("rel", rnd(8192), rnd(8192), rnd(8192), 1'b0, ec, eh);

        foreach (w[k]) w[k] = 0;
        step("zero", 0, 2048, 0, 1'b0, ec, eh);
        chk("zero.c_const", ec, 1024);
        chk("zero.h_const", eh, 512);

        w[2] = 3318; w[5] = 1269; w[8] = -655; w[11] = 1209;
        step("bias", 0, 0, 0, 1'b0, ec, eh);
        chk("bias.c_const", int'(c_t), -429);
        chk("bias.h_const", int'(h_t), -278);

        w[2] = 10240; w[5] = 10240; w[8] = 10240; w[11] = 10240;
        step("ovf", 0, 131071, 0, 1'b0, ec, eh);
`ifdef LSTM_CELL_SAT_EN
        chk("ovf.c_const", int'(c_t), 131071);
        chk("ovf.h_const", int'(h_t), 2048);
`else
        chk("ovf.c_const", int'(c_t), -129025);
        chk("ovf.h_const", int'(h_t), -2048);
`endif

        foreach (w[k]) w[k] = rnd(3072);
        mc = 0;
        mh = 0;
        n = 0;
        for (int x = -10240; x <= 10240; x += 256) begin
            if (n == 40) begin
                step("sweep_rst", x, mc, mh, 1'b1, ec, eh);
                chk("sweep_rst.c_const", int'(c_t), 0);
            end else step("sweep", x, mc, mh, 1'b0, ec, eh);
            mc = ec;
            mh = eh;
            n++;
        end

        for (int k = 0; k < 150; k++) begin
            foreach (w[j]) w[j] = rnd(k < 75 ? 4096 : 131071);
            step("rand", rnd(131071), rnd(131071), rnd(131071), 1'b0, ec, eh);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
